tex_dcache_arb: RTL

- Sits directly downstream of the texture unit's dcache request/response port.
- Shares one per-core dcache lane-port bundle between the LSU (source 0) and the texture unit (source 1).
- Arbitrates whole requests, with round-robin between the two sources.
- Tracks partially accepted lanes so a request is never re-issued on lanes already taken.
- Tags each request with its source and routes dcache responses back by that tag bit.

---
 rtl/tex_dcache_arb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tex_dcache_arb.sv
// Shares one dcache lane-port bundle between the LSU (src 0) and texture unit (src 1).
// Optional stall counters: define DCACHE_ARB_PERF_EN.
module tex_dcache_arb #(
    parameter int NUM_REQS = 4,
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          lsu_req_valid,
    input  logic                         lsu_req_rw,
    input  logic [NUM_REQS*DATA_W/8-1:0] lsu_req_byteen,
    input  logic [NUM_REQS*ADDR_W-1:0]   lsu_req_addr,
    input  logic [NUM_REQS*DATA_W-1:0]   lsu_req_data,
    input  logic [TAG_W-1:0]             lsu_req_tag,
    output logic                         lsu_req_ready,
    input  logic [NUM_REQS-1:0]          tex_req_valid,
    input  logic [NUM_REQS*ADDR_W-1:0]   tex_req_addr,
    input  logic [TAG_W-1:0]             tex_req_tag,
    output logic                         tex_req_ready,
    output logic [NUM_REQS-1:0]          dcache_req_valid,
    output logic                         dcache_req_rw,
    output logic [NUM_REQS*DATA_W/8-1:0] dcache_req_byteen,
    output logic [NUM_REQS*ADDR_W-1:0]   dcache_req_addr,
    output logic [NUM_REQS*DATA_W-1:0]   dcache_req_data,
    output logic [TAG_W:0]               dcache_req_tag,
    input  logic [NUM_REQS-1:0]          dcache_req_ready,
    input  logic                         dcache_rsp_valid,
    input  logic [NUM_REQS-1:0]          dcache_rsp_tmask,
    input  logic [NUM_REQS*DATA_W-1:0]   dcache_rsp_data,
    input  logic [TAG_W:0]               dcache_rsp_tag,
    output logic                         dcache_rsp_ready,
    output logic                         lsu_rsp_valid,
    output logic [NUM_REQS-1:0]          lsu_rsp_tmask,
    output logic [NUM_REQS*DATA_W-1:0]   lsu_rsp_data,
    output logic [TAG_W-1:0]             lsu_rsp_tag,
    input  logic                         lsu_rsp_ready,
    output logic                         tex_rsp_valid,
    output logic [NUM_REQS-1:0]          tex_rsp_tmask,
    output logic [NUM_REQS*DATA_W-1:0]   tex_rsp_data,
    output logic [TAG_W-1:0]             tex_rsp_tag,
    input  logic                         tex_rsp_ready
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [43:0]                  perf_lsu_stalls,
    output logic [43:0]                  perf_tex_stalls
`endif
);

    localparam int BE_W = NUM_REQS * DATA_W / 8;

    logic                grant;
    logic                locked;
    logic                last;
    logic [NUM_REQS-1:0] sent_mask;

    logic                lsu_any;
    logic                tex_any;
    logic                cur_grant;
    logic [NUM_REQS-1:0] gvalid;
    logic [NUM_REQS-1:0] fire;
    logic [NUM_REQS-1:0] rem;
    logic                active;
    logic                done;

    // Pick the owning source: a locked request keeps it, else round-robin on last.
    always_comb begin
        lsu_any = |lsu_req_valid;
        tex_any = |tex_req_valid;
        if (locked)
            cur_grant = grant;
        else if (lsu_any && tex_any)
            cur_grant = ~last;
        else
            cur_grant = tex_any;
        gvalid = cur_grant ? tex_req_valid : lsu_req_valid;
        active = |gvalid;
    end

    assign dcache_req_valid = gvalid & ~sent_mask;
    assign fire = dcache_req_valid & dcache_req_ready;
    assign rem  = dcache_req_valid & ~dcache_req_ready;
    assign done = active && (rem == '0);

    assign lsu_req_ready = done && !cur_grant;
    assign tex_req_ready = done && cur_grant;

    // Texture requests are read-only full-word accesses.
    always_comb begin
        dcache_req_tag = {cur_grant, (cur_grant ? tex_req_tag : lsu_req_tag)};
        if (cur_grant) begin
            dcache_req_rw     = 1'b0;
            dcache_req_byteen = {BE_W{1'b1}};
            dcache_req_addr   = tex_req_addr;
            dcache_req_data   = '0;
        end else begin
            dcache_req_rw     = lsu_req_rw;
            dcache_req_byteen = lsu_req_byteen;
            dcache_req_addr   = lsu_req_addr;
            dcache_req_data   = lsu_req_data;
        end
    end

    // Remember accepted lanes until the whole request retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= 1'b0;
            locked    <= 1'b0;
            last      <= 1'b1;
            sent_mask <= '0;
        end else if (done) begin
            grant     <= cur_grant;
            locked    <= 1'b0;
            last      <= cur_grant;
            sent_mask <= '0;
        end else if (active) begin
            grant     <= cur_grant;
            locked    <= 1'b1;
            sent_mask <= sent_mask | fire;
        end
    end

    // Responses route back on the source bit carried in the tag MSB.
    always_comb begin
        lsu_rsp_valid    = dcache_rsp_valid && !dcache_rsp_tag[TAG_W];
        tex_rsp_valid    = dcache_rsp_valid && dcache_rsp_tag[TAG_W];
        lsu_rsp_tmask    = dcache_rsp_tmask;
        tex_rsp_tmask    = dcache_rsp_tmask;
        lsu_rsp_data     = dcache_rsp_data;
        tex_rsp_data     = dcache_rsp_data;
        lsu_rsp_tag      = dcache_rsp_tag[TAG_W-1:0];
        tex_rsp_tag      = dcache_rsp_tag[TAG_W-1:0];
        dcache_rsp_ready = dcache_rsp_tag[TAG_W] ? tex_rsp_ready : lsu_rsp_ready;
    end

`ifdef DCACHE_ARB_PERF_EN
    // Count cycles a source waits with a request outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lsu_stalls <= '0;
            perf_tex_stalls <= '0;
        end else begin
            if (lsu_any && !lsu_req_ready)
                perf_lsu_stalls <= perf_lsu_stalls + 44'd1;
            if (tex_any && !tex_req_ready)
                perf_tex_stalls <= perf_tex_stalls + 44'd1;
        end
    end
`endif

endmodule
